// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: frame-rate pong game state (paddles, ball, velocity, scores, serve/play/game-over)
module pong_game_ctrl #(
    parameter int H_ACTIVE     = 640,
    parameter int V_ACTIVE     = 480,
    parameter int PADDLE_H     = 64,
    parameter int PADDLE_W     = 8,
    parameter int PADDLE_XL    = 16,
    parameter int PADDLE_XR    = 616,
    parameter int PADDLE_STEP  = 4,
    parameter int BALL_SIZE    = 8,
    parameter int SERVE_FRAMES = 60,
    parameter int WIN_SCORE    = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       left_up,
    input  logic       left_down,
    input  logic       right_up,
    input  logic       right_down,
    input  logic       score_reset,
    input  logic [1:0] speed,
    output logic [9:0] paddle_l_y,
    output logic [9:0] paddle_r_y,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic [3:0] score_l,
    output logic [3:0] score_r,
    output logic [1:0] game_state,
    output logic       point_pulse
);
    localparam int CW = $clog2(SERVE_FRAMES + 1);
    localparam logic signed [10:0] PS     = 11'(PADDLE_STEP);
    localparam logic signed [10:0] P_MAX  = 11'(V_ACTIVE - PADDLE_H);
    localparam logic signed [10:0] PH     = 11'(PADDLE_H);
    localparam logic signed [10:0] BS     = 11'(BALL_SIZE);
    localparam logic signed [10:0] Y_MAX  = 11'(V_ACTIVE - BALL_SIZE);
    localparam logic signed [10:0] X_MAX  = 11'(H_ACTIVE - BALL_SIZE);
    localparam logic signed [10:0] FACE_L = 11'(PADDLE_XL + PADDLE_W);
    localparam logic signed [10:0] FACE_R = 11'(PADDLE_XR);
    localparam logic [9:0] P_INIT   = 10'((V_ACTIVE - PADDLE_H) / 2);
    localparam logic [9:0] BX_INIT  = 10'((H_ACTIVE - BALL_SIZE) / 2);
    localparam logic [9:0] BY_INIT  = 10'((V_ACTIVE - BALL_SIZE) / 2);
    localparam logic [9:0] BX_HIT_L = 10'(PADDLE_XL + PADDLE_W);
    localparam logic [9:0] BX_HIT_R = 10'(PADDLE_XR - BALL_SIZE);
    localparam logic [9:0] BY_BOT   = 10'(V_ACTIVE - BALL_SIZE);
    localparam logic [CW-1:0] CNT_INIT = CW'(SERVE_FRAMES);
    localparam logic [3:0] WIN = 4'(WIN_SCORE);

    typedef enum logic [1:0] {SERVE = 2'd0, PLAY = 2'd1, GAME_OVER = 2'd2} state_t;

    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [9:0] pl, pr, bx, by, pl_n, pr_n, bx_n, by_n, pl_t, pr_t;
    logic [3:0] sl, sr, sl_n, sr_n;
    logic dx_neg, dy_neg, dx_n, dy_n, pp, pp_n;
    logic signed [10:0] step, x, y, pl_s, pr_s;
    logic top, bot, olap_l, olap_r, hit_l, hit_r, miss_l, miss_r;

    function automatic logic [9:0] paddle_next(input logic [9:0] py, input logic up, input logic dn);
        logic signed [10:0] t;
        t = $signed({1'b0, py}) + ((up && !dn) ? -PS : (dn && !up) ? PS : 11'sd0);
        return (t < 0) ? 10'd0 : (t > P_MAX) ? 10'(P_MAX) : 10'(t);
    endfunction

    assign step   = $signed({9'd0, speed}) + 11'sd1;
    assign x      = $signed({1'b0, bx});
    assign y      = $signed({1'b0, by});
    assign pl_t   = paddle_next(pl, left_up, left_down);
    assign pr_t   = paddle_next(pr, right_up, right_down);
    assign pl_s   = $signed({1'b0, pl_t});
    assign pr_s   = $signed({1'b0, pr_t});
    assign olap_l = (y + BS > pl_s) && (y < pl_s + PH);
    assign olap_r = (y + BS > pr_s) && (y < pr_s + PH);
    assign hit_l  = dx_neg && (x >= FACE_L) && (x - step < FACE_L) && olap_l;
    assign hit_r  = !dx_neg && (x + BS <= FACE_R) && (x + BS + step > FACE_R) && olap_r;
    assign miss_l = dx_neg && (x < step);
    assign miss_r = !dx_neg && (x + step > X_MAX);
    assign top    = dy_neg && (y < step);
    assign bot    = !dy_neg && (y + step > Y_MAX);

    // next game state: score_reset overrides everything, otherwise advance once per frame tick
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        pl_n    = pl;
        pr_n    = pr;
        bx_n    = bx;
        by_n    = by;
        dx_n    = dx_neg;
        dy_n    = dy_neg;
        sl_n    = sl;
        sr_n    = sr;
        pp_n    = 1'b0;
        if (score_reset) begin
            state_n = SERVE;
            cnt_n   = CNT_INIT;
            bx_n    = BX_INIT;
            by_n    = BY_INIT;
            dx_n    = 1'b0;
            sl_n    = '0;
            sr_n    = '0;
        end else if (frame_tick && state != GAME_OVER) begin
            pl_n = pl_t;
            pr_n = pr_t;
            if (state == SERVE) begin
                cnt_n   = (cnt == CW'(1)) ? CNT_INIT : cnt - 1'b1;
                state_n = (cnt == CW'(1)) ? PLAY : SERVE;
            end else if (miss_l || miss_r) begin
                pp_n = 1'b1;
                sl_n = miss_r ? sl + 4'd1 : sl;
                sr_n = miss_l ? sr + 4'd1 : sr;
                if ((miss_r ? sl : sr) + 4'd1 == WIN) begin
                    state_n = GAME_OVER;
                end else begin
                    state_n = SERVE;
                    cnt_n   = CNT_INIT;
                    bx_n    = BX_INIT;
                    by_n    = BY_INIT;
                    dx_n    = miss_l;
                end
            end else begin
                bx_n = hit_l ? BX_HIT_L : hit_r ? BX_HIT_R : 10'(x + (dx_neg ? -step : step));
                dx_n = hit_l ? 1'b0 : hit_r ? 1'b1 : dx_neg;
                by_n = top ? 10'd0 : bot ? BY_BOT : 10'(y + (dy_neg ? -step : step));
                dy_n = top ? 1'b0 : bot ? 1'b1 : dy_neg;
            end
        end
    end

    // game state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= SERVE;
            cnt    <= CNT_INIT;
            pl     <= P_INIT;
            pr     <= P_INIT;
            bx     <= BX_INIT;
            by     <= BY_INIT;
            dx_neg <= 1'b0;
            dy_neg <= 1'b0;
            sl     <= '0;
            sr     <= '0;
            pp     <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            pl     <= pl_n;
            pr     <= pr_n;
            bx     <= bx_n;
            by     <= by_n;
            dx_neg <= dx_n;
            dy_neg <= dy_n;
            sl     <= sl_n;
            sr     <= sr_n;
            pp     <= pp_n;
        end
    end

    assign paddle_l_y  = pl;
    assign paddle_r_y  = pr;
    assign ball_x      = bx;
    assign ball_y      = by;
    assign score_l     = sl;
    assign score_r     = sr;
    assign game_state  = state;
    assign point_pulse = pp;
endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb_pong_game_ctrl: randomized scoreboard bench for pong_game_ctrl against a behavioural game model
module tb_pong_game_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       frame_tick, left_up, left_down, right_up, right_down, score_reset;
    logic [1:0] speed;
    logic [9:0] paddle_l_y, paddle_r_y, ball_x, ball_y;
    logic [3:0] score_l, score_r;
    logic [1:0] game_state;
    logic       point_pulse;

    always #5 clk = ~clk;

    pong_game_ctrl dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick),
        .left_up(left_up), .left_down(left_down), .right_up(right_up), .right_down(right_down),
        .score_reset(score_reset), .speed(speed),
        .paddle_l_y(paddle_l_y), .paddle_r_y(paddle_r_y), .ball_x(ball_x), .ball_y(ball_y),
        .score_l(score_l), .score_r(score_r), .game_state(game_state), .point_pulse(point_pulse)
    );

    typedef struct packed { int pl; int pr; int bx; int by; int sl; int sr; int st; int pp; } snap_t;

    snap_t exp_q[$];
    int total = 0;
    int bad = 0;
    bit mon_on = 1'b0;

    // game model: positions in pixels, directions as +1/-1, state 0/1/2
    int m_pl, m_pr, m_bx, m_by, m_dx, m_dy, m_sl, m_sr, m_st, m_cnt, m_pp;

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v < lo) ? lo : (v > hi) ? hi : v;
    endfunction

    function automatic snap_t model_snap();
        snap_t s;
        s.pl = m_pl; s.pr = m_pr; s.bx = m_bx; s.by = m_by;
        s.sl = m_sl; s.sr = m_sr; s.st = m_st; s.pp = m_pp;
        return s;
    endfunction

    task automatic model_score_reset();
        m_sl = 0; m_sr = 0; m_st = 0; m_cnt = 60;
        m_bx = 316; m_by = 236; m_dx = 1; m_pp = 0;
    endtask

    task automatic model_point(input bit left_missed);
        int sc;
        m_pp = 1;
        if (left_missed) begin m_sr++; sc = m_sr; end
        else begin m_sl++; sc = m_sl; end
        if (sc == 9) m_st = 2;
        else begin
            m_st = 0; m_cnt = 60; m_bx = 316; m_by = 236;
            m_dx = left_missed ? -1 : 1;
        end
    endtask

    task automatic model_tick(input bit lu, input bit ld, input bit ru, input bit rd, input int spd);
        int s;
        bit ol_l, ol_r;
        m_pp = 0;
        if (m_st == 2) return;
        m_pl = clampi(m_pl + 4 * (int'(ld) - int'(lu)), 0, 416);
        m_pr = clampi(m_pr + 4 * (int'(rd) - int'(ru)), 0, 416);
        if (m_st == 0) begin
            m_cnt--;
            if (m_cnt == 0) begin m_cnt = 60; m_st = 1; end
            return;
        end
        s = spd + 1;
        ol_l = (m_by + 8 > m_pl) && (m_by < m_pl + 64);
        ol_r = (m_by + 8 > m_pr) && (m_by < m_pr + 64);
        if (m_dx < 0 && m_bx < s) begin model_point(1'b1); return; end
        if (m_dx > 0 && m_bx + s > 632) begin model_point(1'b0); return; end
        if (m_dx < 0 && m_bx >= 24 && m_bx - s < 24 && ol_l) begin m_bx = 24; m_dx = 1; end
        else if (m_dx > 0 && m_bx + 8 <= 616 && m_bx + 8 + s > 616 && ol_r) begin m_bx = 608; m_dx = -1; end
        else m_bx += m_dx * s;
        if (m_dy < 0 && m_by < s) begin m_by = 0; m_dy = 1; end
        else if (m_dy > 0 && m_by + s > 472) begin m_by = 472; m_dy = -1; end
        else m_by += m_dy * s;
    endtask

    task automatic chk(input string name, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, want, $time);
        end
    endtask

    task automatic chk_snap(input snap_t e);
        chk("paddle_l_y", int'(paddle_l_y), e.pl);
        chk("paddle_r_y", int'(paddle_r_y), e.pr);
        chk("ball_x", int'(ball_x), e.bx);
        chk("ball_y", int'(ball_y), e.by);
        chk("score_l", int'(score_l), e.sl);
        chk("score_r", int'(score_r), e.sr);
        chk("game_state", int'(game_state), e.st);
        chk("point_pulse", int'(point_pulse), e.pp);
    endtask

    task automatic drive(input bit tick, input bit rs, input bit lu, input bit ld,
                         input bit ru, input bit rd, input int spd);
        frame_tick = tick; score_reset = rs;
        left_up = lu; left_down = ld; right_up = ru; right_down = rd;
        speed = 2'(spd);
        if (rs) model_score_reset();
        else if (tick) model_tick(lu, ld, ru, rd, spd);
        if (rs || tick) exp_q.push_back(model_snap());
        @(posedge clk);
        #1;
        frame_tick = 1'b0; score_reset = 1'b0;
    endtask

    // monitor: any cycle that carried a tick or score_reset must show the queued expectation next cycle
    initial begin
        bit ev;
        wait (mon_on);
        forever begin
            @(posedge clk);
            ev = (frame_tick || score_reset) && !rst;
            @(negedge clk);
            if (ev) begin
                if (exp_q.size() == 0) chk("scoreboard_empty", 1, 0);
                else chk_snap(exp_q.pop_front());
            end else chk("point_pulse_idle", int'(point_pulse), 0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; frame_tick = 1'b0; score_reset = 1'b0;
        left_up = 1'b0; left_down = 1'b0; right_up = 1'b0; right_down = 1'b0; speed = 2'd0;
        m_pl = 208; m_pr = 208; m_dy = 1;
        model_score_reset();
        repeat (3) @(posedge clk);
        #1;
        frame_tick = 1'b1;
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
        rst = 1'b0;
        #1;
        chk_snap(model_snap());
        mon_on = 1'b1;
        for (int i = 0; i < 60; i++) drive(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 60; i++) drive(1, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) drive(1, 0, 1, 1, 0, 0, 1);
        drive(1, 1, 0, 1, 1, 0, 3);
        for (int i = 0; i < 8000; i++) begin
            bit lu, ld, ru, rd, rs, tk;
            int spd;
            repeat ($urandom_range(0, 2)) drive(0, 0, $urandom_range(0, 1), $urandom_range(0, 1),
                                                $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3));
            if ((i / 500) % 2 == 1 && $urandom_range(0, 7) != 0) begin
                lu = m_by + 4 < m_pl + 28; ld = m_by + 4 > m_pl + 36;
                ru = m_by + 4 < m_pr + 28; rd = m_by + 4 > m_pr + 36;
            end else begin
                lu = 1'($urandom_range(0, 1)); ld = 1'($urandom_range(0, 1));
                ru = 1'($urandom_range(0, 1)); rd = 1'($urandom_range(0, 1));
            end
            spd = $urandom_range(0, 3);
            rs = (m_st == 2) ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 999) == 0);
            tk = rs ? 1'($urandom_range(0, 1)) : 1'b1;
            drive(tk, rs, lu, ld, ru, rd, spd);
        end
        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
